// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch/decode boundary: FD payload struct, NOP encoding
// and fetch FSM state encodings.
package fetch_unit_pkg;

  localparam int unsigned IMEM_ADDR_W_DEFAULT = 10;

  // addi x0, x0, 0
  localparam logic [31:0] kNOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]                    instruction_fd;
    logic [IMEM_ADDR_W_DEFAULT-1:0] PC_r_fd;
  } fd_s;

  typedef logic [1:0] fetch_state_e;

  localparam fetch_state_e StReq  = 2'd0;
  localparam fetch_state_e StWait = 2'd1;
  localparam fetch_state_e StHold = 2'd2;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one word read at a time to instruction
// memory and presents the fetched word (or a NOP bubble) to the FD register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned            IMEM_ADDR_W = IMEM_ADDR_W_DEFAULT,
  parameter logic [IMEM_ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   bubble,
  input  logic                   flush,
  input  logic [IMEM_ADDR_W-1:0] redirect_pc,
  output logic                   imem_req_valid,
  output logic [IMEM_ADDR_W-1:0] imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  output fd_s                    fd_s_o,
  output logic                   fetch_valid
);

  fetch_state_e           state_q, state_d;
  logic [IMEM_ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]            buf_q, buf_d;
  logic                   discard_q, discard_d;

  logic advance;
  logic req_fire;

  assign advance  = ~(stall | bubble);
  assign req_fire = imem_req_valid & imem_req_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    discard_d = discard_q;
    if (flush) begin
      pc_d = redirect_pc;
      unique case (state_q)
        StWait: begin
          if (imem_rsp_valid) begin
            state_d   = StReq;
            discard_d = 1'b0;
          end else begin
            state_d   = StWait;
            discard_d = 1'b1;
          end
        end
        StReq: begin
          // A request accepted in the flush cycle is already in flight; its data must be dropped.
          if (req_fire) begin
            state_d   = StWait;
            discard_d = 1'b1;
          end else begin
            state_d   = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StReq: begin
          if (req_fire) begin
            state_d = StWait;
          end
        end
        StWait: begin
          if (imem_rsp_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = StReq;
            end else begin
              buf_d   = imem_rsp_data;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (advance) begin
            pc_d    = pc_q + IMEM_ADDR_W'(1);
            state_d = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StReq;
      pc_q      <= RESET_PC;
      buf_q     <= kNOP;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      discard_q <= discard_d;
    end
  end

  // The buffer is valid exactly in HOLD, and it always belongs to the current PC.
  assign imem_req_valid        = (state_q == StReq) & ~reset;
  assign imem_req_addr         = pc_q;
  assign fetch_valid           = (state_q == StHold);
  assign fd_s_o.instruction_fd = fetch_valid ? buf_q : kNOP;
  assign fd_s_o.PC_r_fd        = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small variable-latency instruction memory
// model returning 0x1000_0000 + address.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        bubble;
  logic        flush;
  logic [9:0]  redirect_pc;
  logic        imem_req_valid;
  logic [9:0]  imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  fd_s         fd_s_o;
  logic        fetch_valid;

  int checks = 0;
  int errors = 0;

  int         mem_lat = 1;
  logic       pend = 1'b0;
  int         cnt = 0;
  logic [9:0] pend_addr = '0;
  logic       seen7 = 1'b0;

  fetch_unit #(
    .IMEM_ADDR_W(10),
    .RESET_PC   (10'd0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .bubble        (bubble),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .fd_s_o        (fd_s_o),
    .fetch_valid   (fetch_valid)
  );

  always #5 clk = ~clk;

  // Memory model: mem_lat = 1 means the response is sampled on the edge after accept.
  always @(posedge clk) begin
    imem_rsp_valid <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= 32'h1000_0000 + 32'(pend_addr);
        pend           <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      if (mem_lat <= 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= 32'h1000_0000 + 32'(imem_req_addr);
      end else begin
        pend      <= 1'b1;
        cnt       <= mem_lat - 1;
        pend_addr <= imem_req_addr;
      end
    end
    if (fetch_valid && fd_s_o.PC_r_fd == 10'd7) seen7 <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(output logic found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fetch_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [41:0] exp_fd;
    exp_fd = {kNOP, 10'd0};
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 || fd_s_o !== exp_fd) begin
        errors++;
        $display("FAIL reset_hold: req_valid=%b fetch_valid=%b fd=%h, want 0 0 %h",
                 imem_req_valid, fetch_valid, fd_s_o, exp_fd);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_first_req: valid=%b addr=%h, want 1 000", imem_req_valid,
               imem_req_addr);
    end
  endtask

  task automatic test_stream();
    logic [9:0]  exp_pc;
    logic        exp_fv;
    logic [31:0] exp_ins;
    for (int t = 1; t <= 9; t++) begin
      tick();
      exp_pc  = 10'(t / 3);
      exp_fv  = (t % 3 == 2);
      exp_ins = exp_fv ? 32'h1000_0000 + 32'(exp_pc) : kNOP;
      checks++;
      if (fetch_valid !== exp_fv || fd_s_o !== {exp_ins, exp_pc}) begin
        errors++;
        $display("FAIL stream_t%0d: fv=%b fd=%h, want fv=%b fd=%h", t, fetch_valid, fd_s_o,
                 exp_fv, {exp_ins, exp_pc});
      end
    end
    imem_req_ready = 1'b0;
  endtask

  task automatic test_ready_low();
    logic [9:0] exp_addr;
    logic       found;
    for (int c = 0; c < 5; c++) begin
      exp_addr = (c < 3) ? 10'h003 : 10'h010;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_addr) begin
        errors++;
        $display("FAIL ready_low_c%0d: valid=%b addr=%h, want 1 %h", c, imem_req_valid,
                 imem_req_addr, exp_addr);
      end
      flush       = (c == 2);
      redirect_pc = 10'h010;
      tick();
      flush = 1'b0;
    end
    imem_req_ready = 1'b1;
    wait_fetch(found);
    checks++;
    if (!found || fd_s_o !== {32'h1000_0010, 10'h010}) begin
      errors++;
      $display("FAIL ready_low_fetch: found=%b fd=%h, want 1 %h", found, fd_s_o,
               {32'h1000_0010, 10'h010});
    end
  endtask

  task automatic test_stall();
    logic found;
    flush       = 1'b1;
    redirect_pc = 10'd5;
    tick();
    flush = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 10'd5) begin
      errors++;
      $display("FAIL stall_redirect: fv=%b valid=%b addr=%h, want 0 1 005", fetch_valid,
               imem_req_valid, imem_req_addr);
    end
    wait_fetch(found);
    checks++;
    if (!found || fd_s_o !== {32'h1000_0005, 10'd5}) begin
      errors++;
      $display("FAIL stall_fetch5: found=%b fd=%h", found, fd_s_o);
    end
    for (int i = 0; i < 6; i++) begin
      stall  = (i < 4);
      bubble = (i >= 4);
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || imem_req_valid !== 1'b0 ||
          fd_s_o !== {32'h1000_0005, 10'd5}) begin
        errors++;
        $display("FAIL stall_hold_c%0d: fv=%b valid=%b fd=%h, want 1 0 %h", i, fetch_valid,
                 imem_req_valid, fd_s_o, {32'h1000_0005, 10'd5});
      end
    end
    stall          = 1'b0;
    bubble         = 1'b0;
    imem_req_ready = 1'b0;
    tick();
    checks++;
    if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 10'd6) begin
      errors++;
      $display("FAIL stall_release: fv=%b valid=%b addr=%h, want 0 1 006", fetch_valid,
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_flush_wait();
    logic found;
    flush       = 1'b1;
    redirect_pc = 10'd7;
    tick();
    flush = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'd7) begin
      errors++;
      $display("FAIL flush_req7: valid=%b addr=%h, want 1 007", imem_req_valid, imem_req_addr);
    end
    mem_lat        = 3;
    imem_req_ready = 1'b1;
    tick();
    flush          = 1'b1;
    redirect_pc    = 10'h040;
    imem_req_ready = 1'b0;
    tick();
    flush = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 || fd_s_o.PC_r_fd !== 10'h040) begin
      errors++;
      $display("FAIL flush_in_wait: valid=%b fv=%b pc=%h, want 0 0 040", imem_req_valid,
               fetch_valid, fd_s_o.PC_r_fd);
    end
    tick();
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'h040 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: valid=%b addr=%h fv=%b, want 1 040 0", imem_req_valid,
               imem_req_addr, fetch_valid);
    end
    mem_lat        = 1;
    imem_req_ready = 1'b1;
    wait_fetch(found);
    checks++;
    if (!found || fd_s_o !== {32'h1000_0040, 10'h040} || seen7 !== 1'b0) begin
      errors++;
      $display("FAIL flush_fetch40: found=%b fd=%h seen7=%b, want 1 %h 0", found, fd_s_o,
               seen7, {32'h1000_0040, 10'h040});
    end
  endtask

  task automatic test_wrap();
    logic found;
    flush       = 1'b1;
    redirect_pc = 10'h3FF;
    tick();
    flush = 1'b0;
    wait_fetch(found);
    checks++;
    if (!found || fd_s_o !== {32'h1000_03FF, 10'h3FF}) begin
      errors++;
      $display("FAIL wrap_fetch: found=%b fd=%h", found, fd_s_o);
    end
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'h000) begin
      errors++;
      $display("FAIL wrap_next: valid=%b addr=%h, want 1 000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_reset_wait();
    logic found;
    imem_req_ready = 1'b0;
    flush          = 1'b1;
    redirect_pc    = 10'h020;
    tick();
    flush          = 1'b0;
    mem_lat        = 3;
    imem_req_ready = 1'b1;
    tick();
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 || fd_s_o !== {kNOP, 10'd0}) begin
      errors++;
      $display("FAIL rst_wait_in_reset: valid=%b fv=%b fd=%h", imem_req_valid, fetch_valid,
               fd_s_o);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'd0 || fetch_valid !== 1'b0 ||
          fd_s_o !== {kNOP, 10'd0}) begin
        errors++;
        $display("FAIL rst_wait_stale_c%0d: valid=%b addr=%h fv=%b fd=%h", i, imem_req_valid,
                 imem_req_addr, fetch_valid, fd_s_o);
      end
    end
    mem_lat        = 1;
    imem_req_ready = 1'b1;
    wait_fetch(found);
    checks++;
    if (!found || fd_s_o !== {32'h1000_0000, 10'd0}) begin
      errors++;
      $display("FAIL rst_wait_refetch: found=%b fd=%h", found, fd_s_o);
    end
  endtask

  initial begin
    stall          = 1'b0;
    bubble         = 1'b0;
    flush          = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    reset          = 1'b1;
    test_reset();
    test_stream();
    test_ready_low();
    test_stall();
    test_flush_wait();
    test_wrap();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks,
             errors);
    $fatal(1);
  end

endmodule
